// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: state encodings, winner codes
// and game-grid constants.
package pong_pkg;

  localparam int unsigned c_GAME_WIDTH    = 40;
  localparam int unsigned c_GAME_HEIGHT   = 30;
  localparam int unsigned c_PADDLE_HEIGHT = 6;

  localparam int unsigned c_SCORE_W  = 4;
  localparam int unsigned c_WINNER_W = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    RUNNING    = 3'd2,
    P1_POINT   = 3'd3,
    P2_POINT   = 3'd4,
    MATCH_OVER = 3'd5
  } t_match_state;

  localparam logic [c_WINNER_W-1:0] WIN_NONE = 2'b00;
  localparam logic [c_WINNER_W-1:0] WIN_P1   = 2'b01;
  localparam logic [c_WINNER_W-1:0] WIN_P2   = 2'b10;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pong_paddle_hit_check.sv
// Combinational test of whether a ball row lies within a paddle's vertical extent.
// The arithmetic is one bit wider than a row so top + height cannot overflow.
module pong_paddle_hit_check
  import pong_pkg::*;
#(
  parameter int unsigned c_ROW_W = clog2_min1(pong_pkg::c_GAME_HEIGHT)
) (
  input  logic [c_ROW_W-1:0] i_Ball_Y,
  input  logic [c_ROW_W-1:0] i_Paddle_Top,
  input  logic [c_ROW_W:0]   i_Paddle_Height,
  output logic               o_In_Paddle_c
);

  localparam int unsigned c_EXT_W = c_ROW_W + 1;

  logic [c_EXT_W-1:0] w_Ball;
  logic [c_EXT_W-1:0] w_Top;
  logic [c_EXT_W-1:0] w_Bottom;

  always_comb begin
    w_Ball        = {1'b0, i_Ball_Y};
    w_Top         = {1'b0, i_Paddle_Top};
    w_Bottom      = w_Top + i_Paddle_Height - c_EXT_W'(1);
    o_In_Paddle_c = (w_Ball >= w_Top) && (w_Ball <= w_Bottom);
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve timing, miss/hit detection, scoring, rally speed
// levels and the latched match-over/winner state.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned c_GAME_WIDTH     = pong_pkg::c_GAME_WIDTH,
  parameter int unsigned c_GAME_HEIGHT    = pong_pkg::c_GAME_HEIGHT,
  parameter int unsigned c_PADDLE_HEIGHT  = pong_pkg::c_PADDLE_HEIGHT,
  parameter int unsigned c_SCORE_LIMIT    = 9,
  parameter int unsigned c_SERVE_DELAY    = 25000000,
  parameter int unsigned c_HITS_PER_LEVEL = 4,
  parameter int unsigned c_MAX_LEVEL      = 3
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst,
  input  logic                               i_Game_Start,
  input  logic                               i_Ball_Step,
  input  logic [$clog2(c_GAME_WIDTH)-1:0]    i_Ball_X,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0]   i_Ball_Y,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0]   i_Paddle_Y_P1,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0]   i_Paddle_Y_P2,
  output logic                               o_Game_Active,
  output logic                               o_Serve_Dir,
  output logic [3:0]                         o_P1_Score,
  output logic [3:0]                         o_P2_Score,
  output logic [$clog2(c_MAX_LEVEL+1)-1:0]   o_Speed_Level,
  output logic                               o_Match_Over,
  output logic [1:0]                         o_Winner
);

  localparam int unsigned c_X_W   = $clog2(c_GAME_WIDTH);
  localparam int unsigned c_Y_W   = $clog2(c_GAME_HEIGHT);
  localparam int unsigned c_EXT_W = c_Y_W + 1;
  localparam int unsigned c_LVL_W = $clog2(c_MAX_LEVEL + 1);
  localparam int unsigned c_CNT_W = clog2_min1(c_SERVE_DELAY);
  localparam int unsigned c_HIT_W = clog2_min1(c_HITS_PER_LEVEL);

  t_match_state r_State;
  t_match_state w_State_Next;

  logic [c_CNT_W-1:0]    r_Serve_Cnt;
  logic [c_CNT_W-1:0]    w_Serve_Cnt_Next;
  logic [c_HIT_W-1:0]    r_Hit_Cnt;
  logic [c_HIT_W-1:0]    w_Hit_Cnt_Next;
  logic [c_LVL_W-1:0]    w_Level_Next;
  logic                  w_Dir_Next;
  logic [c_SCORE_W-1:0]  w_P1_Next;
  logic [c_SCORE_W-1:0]  w_P2_Next;
  logic [c_WINNER_W-1:0] w_Winner_Next;

  logic r_Start_Q;
  logic r_Start_Arm;
  logic w_Start_Rise;

  logic w_In_P1;
  logic w_In_P2;
  logic w_At_Left;
  logic w_At_Right;
  logic w_Miss_P1;
  logic w_Miss_P2;
  logic w_Hit;

  pong_paddle_hit_check #(
    .c_ROW_W (c_Y_W)
  ) u_hit_p1 (
    .i_Ball_Y        (i_Ball_Y),
    .i_Paddle_Top    (i_Paddle_Y_P1),
    .i_Paddle_Height (c_EXT_W'(c_PADDLE_HEIGHT)),
    .o_In_Paddle_c   (w_In_P1)
  );

  pong_paddle_hit_check #(
    .c_ROW_W (c_Y_W)
  ) u_hit_p2 (
    .i_Ball_Y        (i_Ball_Y),
    .i_Paddle_Top    (i_Paddle_Y_P2),
    .i_Paddle_Height (c_EXT_W'(c_PADDLE_HEIGHT)),
    .o_In_Paddle_c   (w_In_P2)
  );

  // The arm flag blocks a press that was already held when reset released.
  always_comb begin
    w_Start_Rise = i_Game_Start & ~r_Start_Q & r_Start_Arm;
    w_At_Left    = (i_Ball_X == '0);
    w_At_Right   = (i_Ball_X == c_X_W'(c_GAME_WIDTH - 1));
    w_Miss_P1    = w_At_Left  & ~w_In_P1;
    w_Miss_P2    = w_At_Right & ~w_In_P2;
    w_Hit        = i_Ball_Step & ((w_At_Left & w_In_P1) | (w_At_Right & w_In_P2));
  end

  // Next-state and next-output logic.
  always_comb begin
    w_State_Next     = r_State;
    w_Serve_Cnt_Next = '0;
    w_Hit_Cnt_Next   = r_Hit_Cnt;
    w_Level_Next     = o_Speed_Level;
    w_Dir_Next       = o_Serve_Dir;
    w_P1_Next        = o_P1_Score;
    w_P2_Next        = o_P2_Score;
    w_Winner_Next    = o_Winner;

    case (r_State)
      IDLE: begin
        if (w_Start_Rise) w_State_Next = SERVE_WAIT;
      end

      SERVE_WAIT: begin
        if (r_Serve_Cnt == c_CNT_W'(c_SERVE_DELAY - 1)) w_State_Next = RUNNING;
        else w_Serve_Cnt_Next = r_Serve_Cnt + c_CNT_W'(1);
      end

      RUNNING: begin
        if (w_Miss_P1) begin
          w_State_Next = P2_POINT;
        end else if (w_Miss_P2) begin
          w_State_Next = P1_POINT;
        end else if (w_Hit) begin
          if (r_Hit_Cnt == c_HIT_W'(c_HITS_PER_LEVEL - 1)) begin
            w_Hit_Cnt_Next = '0;
            if (o_Speed_Level != c_LVL_W'(c_MAX_LEVEL))
              w_Level_Next = o_Speed_Level + c_LVL_W'(1);
          end else begin
            w_Hit_Cnt_Next = r_Hit_Cnt + c_HIT_W'(1);
          end
        end
      end

      P1_POINT: begin
        w_Hit_Cnt_Next = '0;
        w_Level_Next   = '0;
        w_Dir_Next     = 1'b1;
        if (o_P1_Score != c_SCORE_W'(c_SCORE_LIMIT))
          w_P1_Next = o_P1_Score + c_SCORE_W'(1);
        if (w_P1_Next == c_SCORE_W'(c_SCORE_LIMIT)) begin
          w_State_Next  = MATCH_OVER;
          w_Winner_Next = WIN_P1;
        end else begin
          w_State_Next = SERVE_WAIT;
        end
      end

      P2_POINT: begin
        w_Hit_Cnt_Next = '0;
        w_Level_Next   = '0;
        w_Dir_Next     = 1'b0;
        if (o_P2_Score != c_SCORE_W'(c_SCORE_LIMIT))
          w_P2_Next = o_P2_Score + c_SCORE_W'(1);
        if (w_P2_Next == c_SCORE_W'(c_SCORE_LIMIT)) begin
          w_State_Next  = MATCH_OVER;
          w_Winner_Next = WIN_P2;
        end else begin
          w_State_Next = SERVE_WAIT;
        end
      end

      MATCH_OVER: begin
        if (w_Start_Rise) begin
          w_P1_Next     = '0;
          w_P2_Next     = '0;
          w_Winner_Next = WIN_NONE;
          w_State_Next  = SERVE_WAIT;
        end
      end

      default: w_State_Next = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State       <= IDLE;
      r_Serve_Cnt   <= '0;
      r_Hit_Cnt     <= '0;
      r_Start_Q     <= 1'b0;
      r_Start_Arm   <= 1'b0;
      o_Game_Active <= 1'b0;
      o_Serve_Dir   <= 1'b0;
      o_P1_Score    <= '0;
      o_P2_Score    <= '0;
      o_Speed_Level <= '0;
      o_Match_Over  <= 1'b0;
      o_Winner      <= WIN_NONE;
    end else begin
      r_State       <= w_State_Next;
      r_Serve_Cnt   <= w_Serve_Cnt_Next;
      r_Hit_Cnt     <= w_Hit_Cnt_Next;
      r_Start_Q     <= i_Game_Start;
      r_Start_Arm   <= r_Start_Arm | ~i_Game_Start;
      o_Game_Active <= (w_State_Next == RUNNING);
      o_Serve_Dir   <= w_Dir_Next;
      o_P1_Score    <= w_P1_Next;
      o_P2_Score    <= w_P2_Next;
      o_Speed_Level <= w_Level_Next;
      o_Match_Over  <= (w_State_Next == MATCH_OVER);
      o_Winner      <= w_Winner_Next;
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: expected output snapshots are queued as
// stimulus is driven and compared against sampled DUT outputs by each test task.
module tb_pong_match_ctrl;

  logic       i_Clk;
  logic       i_Rst;
  logic       i_Game_Start;
  logic       i_Ball_Step;
  logic [5:0] i_Ball_X;
  logic [4:0] i_Ball_Y;
  logic [4:0] i_Paddle_Y_P1;
  logic [4:0] i_Paddle_Y_P2;
  logic       o_Game_Active;
  logic       o_Serve_Dir;
  logic [3:0] o_P1_Score;
  logic [3:0] o_P2_Score;
  logic [1:0] o_Speed_Level;
  logic       o_Match_Over;
  logic [1:0] o_Winner;

  pong_match_ctrl #(
    .c_GAME_WIDTH     (40),
    .c_GAME_HEIGHT    (30),
    .c_PADDLE_HEIGHT  (6),
    .c_SCORE_LIMIT    (3),
    .c_SERVE_DELAY    (4),
    .c_HITS_PER_LEVEL (2),
    .c_MAX_LEVEL      (3)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Game_Start  (i_Game_Start),
    .i_Ball_Step   (i_Ball_Step),
    .i_Ball_X      (i_Ball_X),
    .i_Ball_Y      (i_Ball_Y),
    .i_Paddle_Y_P1 (i_Paddle_Y_P1),
    .i_Paddle_Y_P2 (i_Paddle_Y_P2),
    .o_Game_Active (o_Game_Active),
    .o_Serve_Dir   (o_Serve_Dir),
    .o_P1_Score    (o_P1_Score),
    .o_P2_Score    (o_P2_Score),
    .o_Speed_Level (o_Speed_Level),
    .o_Match_Over  (o_Match_Over),
    .o_Winner      (o_Winner)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [14:0] obs_q[$];
  int          n_run  = 0;
  int          n_fail = 0;

  // Reference model of the outputs, advanced by the stimulus tasks.
  logic       e_act, e_dir, e_mo;
  logic [3:0] e_p1, e_p2;
  logic [1:0] e_lvl, e_win;
  int         e_hits;

  logic [14:0] obs;
  assign obs = {o_Game_Active, o_Serve_Dir, o_P1_Score, o_P2_Score,
                o_Speed_Level, o_Match_Over, o_Winner};

  function automatic logic [14:0] exp_now();
    return {e_act, e_dir, e_p1, e_p2, e_lvl, e_mo, e_win};
  endfunction

  task automatic sample(input string name);
    exp_t it;
    it.name = name;
    it.v    = exp_now();
    exp_q.push_back(it);
    obs_q.push_back(obs);
  endtask

  task automatic step(input string name);
    exp_t it;
    it.name = name;
    it.v    = exp_now();
    exp_q.push_back(it);
    @(posedge i_Clk);
    #1;
    obs_q.push_back(obs);
  endtask

  task automatic park_ball();
    i_Ball_Step = 1'b0;
    i_Ball_X    = 6'd20;
    i_Ball_Y    = 5'd10;
  endtask

  task automatic hit(input bit left);
    i_Ball_Y    = 5'd10;
    i_Ball_X    = left ? 6'd0 : 6'd39;
    i_Ball_Step = 1'b1;
    e_hits++;
    if (e_hits == 2) begin
      e_hits = 0;
      if (e_lvl != 2'd3) e_lvl = e_lvl + 2'd1;
    end
    step("hit");
    i_Ball_Step = 1'b0;
    step("hit_gap");
  endtask

  // Drives a miss, the one-cycle point state and (if the match continues) the serve.
  task automatic point(input bit p1_scores, input bit with_step);
    i_Ball_Y    = 5'd2;
    i_Ball_Step = with_step;
    i_Ball_X    = p1_scores ? 6'd39 : 6'd0;
    e_act = 1'b0;
    step("point_detect");
    park_ball();
    e_lvl  = 2'd0;
    e_hits = 0;
    if (p1_scores) begin e_p1 = e_p1 + 4'd1; e_dir = 1'b1; end
    else           begin e_p2 = e_p2 + 4'd1; e_dir = 1'b0; end
    if (e_p1 == 4'd3 || e_p2 == 4'd3) begin
      e_mo  = 1'b1;
      e_win = p1_scores ? 2'b01 : 2'b10;
    end
    step("point_award");
    if (!e_mo) begin
      repeat (3) step("serve_wait");
      e_act = 1'b1;
      step("serve_release");
    end
  endtask

  task automatic test_reset();
    exp_t it; logic [14:0] ov;
    i_Rst = 1'b1; i_Game_Start = 1'b0;
    i_Paddle_Y_P1 = 5'd5; i_Paddle_Y_P2 = 5'd8;
    park_ball();
    {e_act, e_dir, e_p1, e_p2, e_lvl, e_mo, e_win} = '0;
    e_hits = 0;
    repeat (2) @(posedge i_Clk);
    #1;
    sample("reset_state");
    i_Game_Start = 1'b1;
    step("held_in_reset");
    i_Rst = 1'b0;
    repeat (8) step("held_start_idle");
    i_Game_Start = 1'b0;
    step("release_idle");
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front(); ov = obs_q.pop_front(); n_run++;
      if (ov !== it.v) begin
        n_fail++;
        $display("FAIL test_reset/%s: got {act,dir,p1,p2,lvl,mo,win}=%b expected %b", it.name, ov, it.v);
      end
    end
  endtask

  task automatic test_serve_delay();
    exp_t it; logic [14:0] ov;
    i_Game_Start = 1'b1;
    step("start_edge");
    i_Game_Start = 1'b0;
    repeat (2) step("serve_wait");
    i_Game_Start = 1'b1;
    step("serve_start_ignored");
    i_Game_Start = 1'b0;
    e_act = 1'b1;
    step("serve_release");
    step("running_hold");
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front(); ov = obs_q.pop_front(); n_run++;
      if (ov !== it.v) begin
        n_fail++;
        $display("FAIL test_serve_delay/%s: got {act,dir,p1,p2,lvl,mo,win}=%b expected %b", it.name, ov, it.v);
      end
    end
  endtask

  task automatic test_p2_point();
    exp_t it; logic [14:0] ov;
    point(1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front(); ov = obs_q.pop_front(); n_run++;
      if (ov !== it.v) begin
        n_fail++;
        $display("FAIL test_p2_point/%s: got {act,dir,p1,p2,lvl,mo,win}=%b expected %b", it.name, ov, it.v);
      end
    end
  endtask

  task automatic test_speed_levels();
    exp_t it; logic [14:0] ov;
    for (int i = 0; i < 8; i++) hit(i[0] == 1'b0);
    point(1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front(); ov = obs_q.pop_front(); n_run++;
      if (ov !== it.v) begin
        n_fail++;
        $display("FAIL test_speed_levels/%s: got {act,dir,p1,p2,lvl,mo,win}=%b expected %b", it.name, ov, it.v);
      end
    end
  endtask

  task automatic test_miss_over_hit();
    exp_t it; logic [14:0] ov;
    hit(1'b0);
    point(1'b1, 1'b1);
    i_Game_Start = 1'b1;
    step("run_start_ignored");
    i_Game_Start = 1'b0;
    step("run_after_start");
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front(); ov = obs_q.pop_front(); n_run++;
      if (ov !== it.v) begin
        n_fail++;
        $display("FAIL test_miss_over_hit/%s: got {act,dir,p1,p2,lvl,mo,win}=%b expected %b", it.name, ov, it.v);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t it; logic [14:0] ov;
    step("pre_reset_2_1");
    @(negedge i_Clk);
    i_Rst = 1'b1;
    #1;
    {e_act, e_dir, e_p1, e_p2, e_lvl, e_mo, e_win} = '0;
    e_hits = 0;
    sample("async_reset");
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    repeat (6) step("idle_after_reset");
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front(); ov = obs_q.pop_front(); n_run++;
      if (ov !== it.v) begin
        n_fail++;
        $display("FAIL test_async_reset/%s: got {act,dir,p1,p2,lvl,mo,win}=%b expected %b", it.name, ov, it.v);
      end
    end
  endtask

  task automatic test_match_over();
    exp_t it; logic [14:0] ov;
    i_Game_Start = 1'b1;
    step("start_edge");
    i_Game_Start = 1'b0;
    repeat (3) step("serve_wait");
    e_act = 1'b1;
    step("serve_release");
    repeat (3) point(1'b1, 1'b0);
    i_Ball_X = 6'd0; i_Ball_Y = 5'd2; i_Ball_Step = 1'b1;
    repeat (3) step("match_hold");
    park_ball();
    i_Game_Start = 1'b1;
    e_p1 = 4'd0; e_p2 = 4'd0; e_win = 2'b00; e_mo = 1'b0;
    step("restart_edge");
    i_Game_Start = 1'b0;
    repeat (3) step("restart_wait");
    e_act = 1'b1;
    step("restart_release");
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front(); ov = obs_q.pop_front(); n_run++;
      if (ov !== it.v) begin
        n_fail++;
        $display("FAIL test_match_over/%s: got {act,dir,p1,p2,lvl,mo,win}=%b expected %b", it.name, ov, it.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve_delay();
    test_p2_point();
    test_speed_levels();
    test_miss_over_hit();
    test_async_reset();
    test_match_over();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
